// File: rtl/programmable_tick_gen_if.sv
// Control/status bundle for programmable_tick_gen.
// sq_out exists only when TICK_SQUARE_OUT_EN is defined.
interface programmable_tick_gen_if #(
  parameter int CNT_W      = 25,
  parameter int TICK_CNT_W = 8
);
  logic                  clear;
  logic                  en;
  logic                  oneshot;
  logic                  start;
  logic                  period_wr;
  logic [CNT_W-1:0]      period_in;
  logic                  tick;
  logic [TICK_CNT_W-1:0] tick_cnt;
  logic                  busy;
  logic [CNT_W-1:0]      period_q;
`ifdef TICK_SQUARE_OUT_EN
  logic                  sq_out;
`endif

  modport master (
    output clear, en, oneshot, start, period_wr, period_in,
    input  tick, tick_cnt, busy, period_q
`ifdef TICK_SQUARE_OUT_EN
    , input sq_out
`endif
  );

  modport slave (
    input  clear, en, oneshot, start, period_wr, period_in,
    output tick, tick_cnt, busy, period_q
`ifdef TICK_SQUARE_OUT_EN
    , output sq_out
`endif
  );
endinterface

// File: rtl/programmable_tick_gen.sv
// Programmable tick strobe: periodic or one-shot, shadowed period, elapsed-tick count.
// Optional square-wave output sq_out enabled by defining TICK_SQUARE_OUT_EN.
module programmable_tick_gen #(
  parameter int CNT_W          = 25,
  parameter int DEFAULT_PERIOD = 25000000,
  parameter int TICK_CNT_W     = 8
) (
  input  logic                    refclk,
  input  logic                    rst,
  programmable_tick_gen_if.slave  bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN_P = 2'd1;
  localparam logic [1:0] ST_RUN_1 = 2'd2;

  localparam logic [CNT_W-1:0]      DEF_P    = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TICK_CNT_W-1:0] TICK_ONE = {{(TICK_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      pending_reg;
  logic [CNT_W-1:0]      period_q_reg;
  logic [TICK_CNT_W-1:0] tick_cnt_reg;
  logic                  tick_reg;
  logic                  busy_reg;
  logic                  wrap;
`ifdef TICK_SQUARE_OUT_EN
  logic                  sq_reg;
`endif

  // period_q is never zero, so period_q-1 cannot underflow.
  assign wrap = (cnt_reg == (period_q_reg - CNT_ONE));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      tick_reg     <= 1'b0;
      tick_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      pending_reg  <= DEF_P;
      period_q_reg <= DEF_P;
`ifdef TICK_SQUARE_OUT_EN
      sq_reg       <= 1'b0;
`endif
    end else begin
      if (bus.period_wr)
        pending_reg <= (bus.period_in == '0) ? CNT_ONE : bus.period_in;

      if (bus.clear) begin
        state_reg    <= ST_IDLE;
        cnt_reg      <= '0;
        tick_reg     <= 1'b0;
        tick_cnt_reg <= '0;
        busy_reg     <= 1'b0;
`ifdef TICK_SQUARE_OUT_EN
        sq_reg       <= 1'b0;
`endif
      end else begin
        case (state_reg)
          ST_IDLE: begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
            if (!bus.oneshot && bus.en) begin
              state_reg    <= ST_RUN_P;
              busy_reg     <= 1'b1;
              period_q_reg <= pending_reg;
            end else if (bus.oneshot && bus.start) begin
              state_reg    <= ST_RUN_1;
              busy_reg     <= 1'b1;
              period_q_reg <= pending_reg;
            end
          end
          ST_RUN_P, ST_RUN_1: begin
            if (wrap) begin
              // A wrap always emits its tick, even if en drops on this edge.
              cnt_reg      <= '0;
              tick_reg     <= 1'b1;
              tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
              period_q_reg <= pending_reg;
`ifdef TICK_SQUARE_OUT_EN
              sq_reg       <= ~sq_reg;
`endif
              if ((state_reg == ST_RUN_1) || !bus.en) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              tick_reg <= 1'b0;
              if ((state_reg == ST_RUN_P) && !bus.en) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
                cnt_reg   <= '0;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            tick_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tick     = tick_reg;
  assign bus.tick_cnt = tick_cnt_reg;
  assign bus.busy     = busy_reg;
  assign bus.period_q = period_q_reg;
`ifdef TICK_SQUARE_OUT_EN
  assign bus.sq_out   = sq_reg;
`endif
endmodule

// File: doc/programmable_tick_gen.md
Name: programmable_tick_gen

Overview:
- Parametrised successor to the fixed half-second tick generator.
- Produces a one-cycle `tick` pulse every P refclk cycles.
- P is runtime-programmable through a shadow register, with synchronous clear, periodic or one-shot mode, and an elapsed-tick counter.
- Feeds Morse timing logic (dot/dash/gap sequencing) and any other block that needs a slow strobe.

Parameters:
- CNT_W, 25, width of the period counter and of the period registers.
- DEFAULT_PERIOD, 25000000, reset value of the period (0.5 s at 50 MHz).
- TICK_CNT_W, 8, width of the elapsed-tick counter.

Ports:
- refclk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous clear, highest priority after rst.
- en  in  1  periodic-mode run enable, level.
- oneshot  in  1  mode select: 0 = periodic, 1 = one-shot; sampled only in IDLE.
- start  in  1  one-shot trigger pulse; ignored unless in IDLE with oneshot=1.
- period_wr  in  1  write strobe for period_in.
- period_in  in  CNT_W  requested period in cycles.
- tick  out  1  one-cycle strobe, registered.
- tick_cnt  out  TICK_CNT_W  ticks since the last clear/reset; wraps.
- busy  out  1  high while in RUN_P or RUN_1.
- period_q  out  CNT_W  active period currently in use.

Behaviour:
- Reset (rst=1, async) values:
  - state=IDLE, cnt=0, tick=0, tick_cnt=0, busy=0.
  - pending=DEFAULT_PERIOD, period_q=DEFAULT_PERIOD.
- States: IDLE, RUN_P (periodic), RUN_1 (one-shot). busy = (state != IDLE), registered.
- Period programming:
  - period_wr writes period_in into `pending` on the same edge.
  - period_in=0 is clamped to 1.
  - period_q loads from pending on entry to RUN_P/RUN_1 and at every wrap edge. A mid-period write therefore never shortens or stretches the current period.
  - A period_wr coinciding with a wrap edge: the new value is written to pending; period_q loads the old pending value; the new value takes effect at the following wrap.
- IDLE:
  - cnt=0, tick=0.
  - en=1 and oneshot=0 -> RUN_P.
  - start=1 and oneshot=1 -> RUN_1.
  - The entry edge sets cnt=0 and loads period_q.
- RUN_P / RUN_1, each edge:
  - If cnt==period_q-1: cnt<=0, tick<=1, tick_cnt<=tick_cnt+1 (mod 2^TICK_CNT_W), period_q<=pending.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - The first tick is high for the single cycle after edge E+P, where E is the entry edge. Ticks then repeat every period_q cycles.
  - P=1: tick stays high continuously, and tick_cnt increments every cycle.
- RUN_P exit:
  - en=0 -> IDLE on the next edge; cnt<=0, tick<=0, no tick emitted on that edge.
  - If en falls on the same edge as a wrap, the wrap wins: tick=1 is emitted, then state goes to IDLE.
- RUN_1 exit:
  - Leaves RUN_1 -> IDLE on the wrap edge, emitting exactly one tick.
  - en, start and oneshot are ignored while in RUN_1.
- Mode changes: oneshot changing outside IDLE has no effect until the next IDLE.
- clear=1 (synchronous, any state):
  - state=IDLE, cnt=0, tick=0, tick_cnt=0.
  - pending and period_q are retained.
  - clear overrides en, start and any wrap on the same edge.
- rst asserted mid-period: all state returns to reset values immediately, and pending is lost.
- Width rules:
  - cnt, period_q and pending are CNT_W bits unsigned.
  - Comparisons are unsigned, with no overflow beyond 2^CNT_W-1.

Optional Feature:
- Macro: TICK_SQUARE_OUT_EN.
- When defined:
  - Adds output sq_out (1 bit), registered, reset 0.
  - sq_out toggles on every edge that sets tick=1, giving a 50%-duty square wave of period 2*period_q (e.g. a 1 Hz LED blink at the default settings).
  - clear forces sq_out=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench parameters: CNT_W=4, DEFAULT_PERIOD=5.
- Reset/periodic: release rst, hold en=1, oneshot=0 -> first tick 5 cycles after the entry edge, then every 5 cycles; tick_cnt reads 1,2,3; busy=1; period_q=5.
- Shadow update: in RUN_P, write period_in=3 at cnt=1 -> the current period still spans 5 cycles; the following ticks are 3 cycles apart; period_q changes at the wrap edge.
- One-shot: oneshot=1, start pulse -> busy=1 for 5 cycles, exactly one tick, then busy=0; a second start while busy produces no extra tick.
- Clear/en boundaries:
  - clear asserted on a wrap edge -> no tick, tick_cnt=0, state IDLE.
  - en dropped on a wrap edge -> that tick is still emitted.
- Edge values:
  - period_in=0 -> period_q=1 and tick high every cycle.
  - With TICK_CNT_W=2, 5 ticks -> tick_cnt wraps 1,2,3,0,1.
- TICK_SQUARE_OUT_EN defined, period 5 -> sq_out toggles at each tick (high 5 cycles, low 5 cycles); clear forces sq_out=0.
